// File: rtl/router_fsm_nch_if.sv
// Router control bundle: source/register-block/FIFO status in, FSM controls out.
// master drives the status side (stimulus/datapath); slave is the control FSM.
interface router_fsm_nch_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_reset;
  logic              parity_done;
  logic              low_packet_valid;

  logic              write_enb_reg;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              busy;
  logic              addr_err;
  logic [ADDR_W-1:0] dest_ch;
  logic              timeout;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty,
    output soft_reset, parity_done, low_packet_valid,
    input  write_enb_reg, detect_add, lfd_state, ld_state,
    input  laf_state, full_state, rst_int_reg, busy,
    input  addr_err, dest_ch, timeout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty,
    input  soft_reset, parity_done, low_packet_valid,
    output write_enb_reg, detect_add, lfd_state, ld_state,
    output laf_state, full_state, rst_int_reg, busy,
    output addr_err, dest_ch, timeout
  );
endinterface

// File: rtl/router_fsm_nch.sv
// NUM_CH-channel router control FSM: header decode, load sequencing, stalls.
// Ports: clock, resetn (sync, active-low), bus (router_fsm_nch_if.slave).
// Optional: define ROUTER_WAIT_TIMEOUT_EN to bound WAIT_TILL_EMPTY.
module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 32
) (
  input  logic           clock,
  input  logic           resetn,
  router_fsm_nch_if.slave bus
);

  localparam int NSEL = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NCH_W = (ADDR_W+1)'(NUM_CH);

  typedef enum logic [8:0] {
    S_DA   = 9'b000000001,
    S_LFD  = 9'b000000010,
    S_LD   = 9'b000000100,
    S_WTE  = 9'b000001000,
    S_FULL = 9'b000010000,
    S_LAF  = 9'b000100000,
    S_LP   = 9'b001000000,
    S_CPE  = 9'b010000000,
    S_DROP = 9'b100000000
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [NSEL-1:0]   empty_pad;
  logic [NSEL-1:0]   srst_pad;
  logic              hdr_oor;
  logic              hdr_empty;
  logic              dst_empty;
  logic              dst_srst;
  logic              wt_expire;

  // Zero-padded so any ADDR_W index is legal; absent channels read 0.
  always_comb begin
    empty_pad = '0;
    srst_pad  = '0;
    empty_pad[NUM_CH-1:0] = bus.fifo_empty;
    srst_pad[NUM_CH-1:0]  = bus.soft_reset;
  end

  assign hdr_oor   = {1'b0, bus.data_in} >= NCH_W;
  assign hdr_empty = empty_pad[bus.data_in];
  assign dst_empty = empty_pad[dest_q];
  assign dst_srst  = srst_pad[dest_q];

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  assign wt_expire = (state_q == S_WTE) && (cnt_q == LAST)
                     && !dst_empty;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_WTE)
      cnt_d = cnt_q + 1'b1;
    if (state_d == S_WTE && state_q != S_WTE)
      cnt_d = '0;
    // A soft reset in the same cycle cancels the drop, so no pulse.
    tmo_d = wt_expire && (state_d == S_DROP);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.timeout = tmo_q;
`else
  logic unused_wt;
  assign unused_wt   = WAIT_TIMEOUT[0];
  assign wt_expire   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DA: begin
        if (bus.pkt_valid) begin
          if (hdr_oor)        state_d = S_DROP;
          else if (hdr_empty) state_d = S_LFD;
          else                state_d = S_WTE;
        end
      end
      S_LFD:  state_d = S_LD;
      S_LD: begin
        if (bus.fifo_full)       state_d = S_FULL;
        else if (!bus.pkt_valid) state_d = S_LP;
      end
      S_WTE: begin
        if (dst_empty)      state_d = S_LFD;
        else if (wt_expire) state_d = S_DROP;
      end
      S_FULL: begin
        if (!bus.fifo_full) state_d = S_LAF;
      end
      S_LAF: begin
        if (bus.parity_done)            state_d = S_DA;
        else if (!bus.low_packet_valid) state_d = S_LD;
      end
      S_LP:   state_d = S_CPE;
      S_CPE:  state_d = bus.fifo_full ? S_FULL : S_DA;
      S_DROP: begin
        if (!bus.pkt_valid) state_d = S_DA;
      end
      default: state_d = S_DA;
    endcase
    // Only the latched channel's soft reset counts; DROP has no channel.
    if (dst_srst && state_q != S_DA && state_q != S_DROP)
      state_d = S_DA;
  end

  always_comb begin
    dest_d = dest_q;
    if (state_q == S_DA && bus.pkt_valid)
      dest_d = bus.data_in;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_DA;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  assign bus.detect_add    = state_q == S_DA;
  assign bus.lfd_state     = state_q == S_LFD;
  assign bus.ld_state      = state_q == S_LD;
  assign bus.laf_state     = state_q == S_LAF;
  assign bus.full_state    = state_q == S_FULL;
  assign bus.rst_int_reg   = state_q == S_CPE;
  assign bus.addr_err      = state_q == S_DROP;
  assign bus.write_enb_reg = (state_q == S_LD) || (state_q == S_LP)
                             || (state_q == S_LAF);
  assign bus.busy          = !((state_q == S_DA) || (state_q == S_LD)
                               || (state_q == S_DROP));
  assign bus.dest_ch       = dest_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed table-driven bench for router_fsm_nch (NUM_CH=3, ADDR_W=2).
// Each row: inputs before a posedge, expected state/dest after it.
module tb_router_fsm_nch;

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int WT = 8;
`else
  localparam int WT = 32;
`endif

  typedef enum int {
    E_DA, E_LFD, E_LD, E_WTE, E_FULL, E_LAF, E_LP, E_CPE, E_DROP
  } st_e;

  typedef struct {
    logic       rn;
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    st_e        st;
    logic [1:0] dst;
  } vec_t;

  logic clock = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;
  vec_t v[$];

  router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

  router_fsm_nch #(
    .NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(WT)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // {we, detect, lfd, ld, laf, full, rst_int, busy, addr_err}
  function automatic logic [8:0] flags(st_e s);
    case (s)
      E_DA:    return 9'b0_1_0_0_0_0_0_0_0;
      E_LFD:   return 9'b0_0_1_0_0_0_0_1_0;
      E_LD:    return 9'b1_0_0_1_0_0_0_0_0;
      E_WTE:   return 9'b0_0_0_0_0_0_0_1_0;
      E_FULL:  return 9'b0_0_0_0_0_1_0_1_0;
      E_LAF:   return 9'b1_0_0_0_1_0_0_1_0;
      E_LP:    return 9'b1_0_0_0_0_0_0_1_0;
      E_CPE:   return 9'b0_0_0_0_0_0_1_1_0;
      default: return 9'b0_0_0_0_0_0_0_0_1;
    endcase
  endfunction

  function automatic void add(
    logic rn, logic pv, logic [1:0] din, logic ff,
    logic [2:0] fe, logic [2:0] sr, logic pd, logic lpv,
    st_e st, logic [1:0] dst
  );
    vec_t x;
    x.rn = rn; x.pv = pv; x.din = din; x.ff = ff;
    x.fe = fe; x.sr = sr; x.pd = pd; x.lpv = lpv;
    x.st = st; x.dst = dst;
    v.push_back(x);
  endfunction

  task automatic step(input vec_t x, input logic et, input string tag);
    logic [8:0] got;
    resetn               = x.rn;
    bus.pkt_valid        = x.pv;
    bus.data_in          = x.din;
    bus.fifo_full        = x.ff;
    bus.fifo_empty       = x.fe;
    bus.soft_reset       = x.sr;
    bus.parity_done      = x.pd;
    bus.low_packet_valid = x.lpv;
    @(posedge clock);
    #1;
    got = {bus.write_enb_reg, bus.detect_add, bus.lfd_state,
           bus.ld_state, bus.laf_state, bus.full_state,
           bus.rst_int_reg, bus.busy, bus.addr_err};
    total++;
    if (got !== flags(x.st)) begin
      bad++;
      $display("FAIL %s flags got=%b want=%b (%s)",
               tag, got, flags(x.st), x.st.name());
    end
    total++;
    if (bus.dest_ch !== x.dst) begin
      bad++;
      $display("FAIL %s dest_ch got=%0d want=%0d",
               tag, bus.dest_ch, x.dst);
    end
    total++;
    if (bus.timeout !== et) begin
      bad++;
      $display("FAIL %s timeout got=%b want=%b", tag, bus.timeout, et);
    end
  endtask

  task automatic one(
    input logic pv, input logic [1:0] din, input logic [2:0] fe,
    input st_e st, input logic [1:0] dst, input logic et,
    input string tag
  );
    vec_t x;
    x.rn = 1'b1; x.pv = pv; x.din = din; x.ff = 1'b0;
    x.fe = fe; x.sr = 3'b000; x.pd = 1'b0; x.lpv = 1'b0;
    x.st = st; x.dst = dst;
    step(x, et, tag);
  endtask

  initial begin
    // rn pv din ff fe sr pd lpv -> state dest
    add(0,0,0,0,3'b111,0,0,0, E_DA,   0);
    add(1,0,0,0,3'b111,0,0,0, E_DA,   0);
    add(1,1,1,0,3'b111,0,0,0, E_LFD,  1);
    add(1,1,0,0,3'b111,0,0,0, E_LD,   1);
    add(1,1,0,0,3'b111,0,0,0, E_LD,   1);
    add(1,0,0,0,3'b111,0,0,0, E_LP,   1);
    add(1,0,0,0,3'b111,0,0,0, E_CPE,  1);
    add(1,0,0,0,3'b111,0,0,0, E_DA,   1);
    add(1,1,2,0,3'b011,0,0,0, E_WTE,  2);
    add(1,1,0,0,3'b010,0,0,0, E_WTE,  2);
    add(1,1,0,0,3'b011,0,0,0, E_WTE,  2);
    add(1,1,0,0,3'b010,0,0,0, E_WTE,  2);
    add(1,1,0,0,3'b011,3'b001,0,0, E_WTE, 2);
    add(1,1,0,0,3'b100,0,0,0, E_LFD,  2);
    add(1,1,0,0,3'b111,0,0,0, E_LD,   2);
    add(1,1,0,1,3'b111,0,0,0, E_FULL, 2);
    add(1,1,0,1,3'b111,0,0,0, E_FULL, 2);
    add(1,1,0,1,3'b111,0,0,0, E_FULL, 2);
    add(1,1,0,0,3'b111,0,0,0, E_LAF,  2);
    add(1,1,0,0,3'b111,0,0,1, E_LAF,  2);
    add(1,1,0,0,3'b111,0,0,0, E_LD,   2);
    add(1,1,0,1,3'b111,0,0,0, E_FULL, 2);
    add(1,1,0,0,3'b111,0,0,0, E_LAF,  2);
    add(1,1,0,0,3'b111,0,1,1, E_DA,   2);
    add(1,1,3,0,3'b111,0,0,0, E_DROP, 3);
    add(1,1,0,1,3'b111,3'b111,0,0, E_DROP, 3);
    add(1,0,0,0,3'b111,0,0,0, E_DA,   3);
    add(1,0,2,0,3'b000,0,0,0, E_DA,   3);
    add(1,1,1,0,3'b111,3'b010,0,0, E_LFD, 1);
    add(1,1,0,0,3'b111,0,0,0, E_LD,   1);
    add(1,1,0,0,3'b111,3'b001,0,0, E_LD, 1);
    add(1,1,0,0,3'b111,3'b100,0,0, E_LD, 1);
    add(1,1,0,0,3'b111,3'b010,0,0, E_DA, 1);
    add(1,1,1,0,3'b111,0,0,0, E_LFD,  1);
    add(1,1,0,0,3'b111,0,0,0, E_LD,   1);
    add(0,1,0,0,3'b111,0,0,0, E_DA,   0);
    add(1,1,2,0,3'b011,0,0,0, E_WTE,  2);
    add(1,1,0,0,3'b011,3'b100,0,0, E_DA, 2);
    add(1,1,0,0,3'b111,0,0,0, E_LFD,  0);
    add(1,1,0,0,3'b111,0,0,0, E_LD,   0);
    add(1,0,0,1,3'b111,0,0,0, E_FULL, 0);
    add(1,0,0,0,3'b111,0,0,0, E_LAF,  0);
    add(1,0,0,0,3'b111,0,0,0, E_LD,   0);
    add(1,0,0,0,3'b111,0,0,0, E_LP,   0);
    add(1,0,0,1,3'b111,0,0,0, E_CPE,  0);
    add(1,0,0,1,3'b111,0,0,0, E_FULL, 0);
    add(1,0,0,0,3'b111,0,0,0, E_LAF,  0);
    add(1,0,0,0,3'b111,0,1,0, E_DA,   0);
    add(1,0,0,0,3'b111,0,0,0, E_DA,   0);

    for (int i = 0; i < v.size(); i++)
      step(v[i], 1'b0, $sformatf("row%0d", i));

`ifdef ROUTER_WAIT_TIMEOUT_EN
    one(1, 2, 3'b011, E_WTE, 2, 0, "to_hdr");
    for (int i = 0; i < WT - 1; i++)
      one(1, 0, 3'b011, E_WTE, 2, 0, $sformatf("to_wait%0d", i));
    one(1, 0, 3'b011, E_DROP, 2, 1, "to_fire");
    one(1, 0, 3'b011, E_DROP, 2, 0, "to_pulse_end");
    one(0, 0, 3'b011, E_DA,   2, 0, "to_drain");
    one(1, 2, 3'b011, E_WTE, 2, 0, "ew_hdr");
    for (int i = 0; i < WT - 1; i++)
      one(1, 0, 3'b011, E_WTE, 2, 0, $sformatf("ew_wait%0d", i));
    one(1, 0, 3'b100, E_LFD, 2, 0, "ew_empty_wins");
    one(1, 0, 3'b100, E_LD,  2, 0, "ew_ld");
`else
    one(1, 2, 3'b011, E_WTE, 2, 0, "nt_hdr");
    for (int i = 0; i < WT + 8; i++)
      one(1, 0, 3'b011, E_WTE, 2, 0, $sformatf("nt_wait%0d", i));
    one(1, 0, 3'b100, E_LFD, 2, 0, "nt_release");
    one(1, 0, 3'b100, E_LD,  2, 0, "nt_ld");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
